// File: rtl/wb_regfile_hilo.sv
// -----------------------------------------------------------------------------
// wb_regfile_hilo
//   Write-back sink of the pipeline. Holds the general-purpose register file
//   and the HI/LO pair, and consumes the wb_* bundle registered by MEM/WB.
//   Two combinational GPR read ports serve ID, with same-cycle write-through
//   bypass so ID sees a value being written back in this very cycle.
//   HI/LO are presented registered to EX; EX does its own HI/LO forwarding.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-low (0 = reset)
//   we/waddr/wdata GPR write enable, address, data
//   whilo          HI/LO write enable (HI and LO always written together)
//   hi_i/lo_i      HI/LO write data
//   re1/raddr1     read port 1 enable/address, rdata1 combinational data
//   re2/raddr2     read port 2 enable/address, rdata2 combinational data
//   hi_o/lo_o      current HI/LO register values
// -----------------------------------------------------------------------------
module wb_regfile_hilo #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] gpr_r [NUM_REGS];
    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic [DATA_W-1:0] arr1_s;
    logic [DATA_W-1:0] arr2_s;

    // Read-port resolution. Order matters: reset, then enable, then the
    // hardwired-zero entry (so a discarded write to r0 is never bypassed),
    // then write-through bypass, then the stored value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              rst_v,
        input logic              re_v,
        input logic [ADDR_W-1:0] raddr_v,
        input logic              we_v,
        input logic [ADDR_W-1:0] waddr_v,
        input logic [DATA_W-1:0] wdata_v,
        input logic [DATA_W-1:0] stored_v
    );
        logic [DATA_W-1:0] res;
        if (!rst_v) begin
            res = ZERO_DATA;
        end else if (!re_v) begin
            res = ZERO_DATA;
        end else if (raddr_v == ZERO_ADDR) begin
            res = ZERO_DATA;
        end else if (we_v && (waddr_v == raddr_v)) begin
            res = wdata_v;
        end else begin
            res = stored_v;
        end
        return res;
    endfunction

    // GPR array: synchronous clear on reset; writes to entry 0 are dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 32'sd0; i < NUM_REGS; i++) begin
                gpr_r[i] <= ZERO_DATA;
            end
        end else if (we && (waddr != ZERO_ADDR)) begin
            gpr_r[waddr] <= wdata;
        end
    end

    // HI/LO pair: always updated together, independent of the GPR write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi_r <= ZERO_DATA;
            lo_r <= ZERO_DATA;
        end else if (whilo) begin
            hi_r <= hi_i;
            lo_r <= lo_i;
        end
    end

    // Stored-value lookups feeding the read-port resolution.
    always_comb begin
        arr1_s = gpr_r[raddr1];
        arr2_s = gpr_r[raddr2];
    end

    // Read port 1.
    always_comb begin
        rdata1 = read_port(rst, re1, raddr1, we, waddr, wdata, arr1_s);
    end

    // Read port 2.
    always_comb begin
        rdata2 = read_port(rst, re2, raddr2, we, waddr, wdata, arr2_s);
    end

    assign hi_o = hi_r;
    assign lo_o = lo_r;

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// -----------------------------------------------------------------------------
// tb_wb_regfile_hilo
//   Scoreboard bench for wb_regfile_hilo. Each cycle the stimulus is driven
//   after the falling edge; the expected rdata1/rdata2/hi_o/lo_o for that
//   cycle (from a behavioural model, plus any fixed values a directed step
//   adds) are pushed to a queue, then popped and compared shortly after. The
//   model is then advanced at the rising edge.
// -----------------------------------------------------------------------------
module tb_wb_regfile_hilo;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    wb_regfile_hilo #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard entry: which output (0 rdata1, 1 rdata2, 2 hi_o, 3 lo_o).
    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t    sb_q[$];
    int          n_checks;
    int          n_fails;

    logic [31:0] gpr_m [32];
    logic [31:0] hi_m;
    logic [31:0] lo_m;
    logic        hilo_known;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic r, input logic e, input logic [4:0] a,
                                             input logic w_e, input logic [4:0] wa,
                                             input logic [31:0] wd);
        if (r == 1'b0)                 return 32'h0;
        if (e == 1'b0)                 return 32'h0;
        if (a == 5'd0)                 return 32'h0;
        if (w_e == 1'b1 && wa == a)    return wd;
        return gpr_m[a];
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    // One bus cycle: drive, score combinational/registered outputs, advance model.
    task automatic step(input string tag, input logic r,
                        input logic w_e, input logic [4:0] wa, input logic [31:0] wd,
                        input logic wh, input logic [31:0] hv, input logic [31:0] lv,
                        input logic e1, input logic [4:0] a1,
                        input logic e2, input logic [4:0] a2);
        sb_item_t it;
        logic [31:0] obs;
        @(negedge clk);
        rst = r; we = w_e; waddr = wa; wdata = wd;
        whilo = wh; hi_i = hv; lo_i = lv;
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
        push({tag, ".rd1"}, 0, model_rd(r, e1, a1, w_e, wa, wd));
        push({tag, ".rd2"}, 1, model_rd(r, e2, a2, w_e, wa, wd));
        if (hilo_known) begin
            push({tag, ".hi"}, 2, hi_m);
            push({tag, ".lo"}, 3, lo_m);
        end
        #2;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.sel)
                0:       obs = rdata1;
                1:       obs = rdata2;
                2:       obs = hi_o;
                default: obs = lo_o;
            endcase
            chk_eq(it.tag, obs, it.exp);
        end
        @(posedge clk);
        if (r == 1'b0) begin
            for (int i = 0; i < 32; i++) gpr_m[i] = 32'h0;
            hi_m = 32'h0;
            lo_m = 32'h0;
            hilo_known = 1'b1;
        end else begin
            if (w_e && wa != 5'd0) gpr_m[wa] = wd;
            if (wh) begin
                hi_m = hv;
                lo_m = lv;
            end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        hilo_known = 1'b0;
        rst = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        whilo = 1'b0; hi_i = 32'h0; lo_i = 32'h0;
        re1 = 1'b0; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd0;

        // 1: reset for two cycles, then release with reads enabled.
        step("rst0", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
        step("rst1", 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);
        push("t1.rd1c", 0, 32'h0);
        push("t1.rd2c", 1, 32'h0);
        push("t1.hic", 2, 32'h0);
        push("t1.loc", 3, 32'h0);
        step("t1", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd31);

        // 2: write-through bypass, then stored value.
        push("t2.bypc", 0, 32'hDEADBEEF);
        step("t2a", 1'b1, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
        push("t2.stc", 0, 32'hDEADBEEF);
        step("t2b", 1'b1, 1'b0, 5'd3, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3);

        // 3: write to r0 is neither bypassed nor stored.
        push("t3.wc", 0, 32'h0);
        step("t3a", 1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
        push("t3.rc", 0, 32'h0);
        step("t3b", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);

        // 4: read enable gates the port.
        step("t4a", 1'b1, 1'b1, 5'd7, 32'h11, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        push("t4.dis", 0, 32'h0);
        push("t4.en", 1, 32'h11);
        step("t4b", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd7, 1'b1, 5'd7);

        // 5: simultaneous GPR and HI/LO write; HI/LO not visible until after the edge.
        push("t5.hiold", 2, 32'h0);
        step("t5a", 1'b1, 1'b1, 5'd9, 32'h5, 1'b1, 32'hAAAA0000, 32'h0000BBBB, 1'b1, 5'd9, 1'b1, 5'd9);
        push("t5.hic", 2, 32'hAAAA0000);
        push("t5.loc", 3, 32'h0000BBBB);
        push("t5.gprc", 0, 32'h5);
        step("t5b", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);

        // 6: reset dominates concurrent writes.
        step("t6a", 1'b0, 1'b1, 5'd4, 32'hFF, 1'b1, 32'h1, 32'h2, 1'b1, 5'd4, 1'b1, 5'd4);
        push("t6.gprc", 0, 32'h0);
        push("t6.hic", 2, 32'h0);
        push("t6.loc", 3, 32'h0);
        step("t6b", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b1, 5'd9);

        // Random traffic with occasional reset; small address range for frequent hits.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a1;
            logic [4:0] a2;
            a1 = 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            step("rnd",
                 ($urandom_range(0, 39) != 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) == 0), $urandom, $urandom,
                 ($urandom_range(0, 7) != 0), a1,
                 ($urandom_range(0, 7) != 0), a2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
